lsu_pipe: RTL and testbench

LSU_PIPE -- requirements
Module: lsu_pipe

---
 rtl/lsu_pipe_pkg.sv | 36 +++
 rtl/lsu_bank_ram.sv | 27 ++
 rtl/lsu_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_lsu_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pipe_pkg.sv
// Shared types for the load/store pipe: access-type encoding, FSM states and size helpers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package lsu_pipe_pkg;

  typedef enum logic [2:0] {
    DT_BYTE  = 3'b000,
    DT_HALF  = 3'b001,
    DT_WORD  = 3'b010,
    DT_BYTEU = 3'b011,
    DT_HALFU = 3'b100
  } dtype_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    RESP = 2'd3
  } state_e;

  // Access size in bytes; 0 marks an illegal encoding.
  function automatic logic [3:0] dtype_size(input logic [2:0] dt);
    case (dt)
      DT_BYTE, DT_BYTEU: dtype_size = 4'd1;
      DT_HALF, DT_HALFU: dtype_size = 4'd2;
      DT_WORD:           dtype_size = 4'd4;
      default:           dtype_size = 4'd0;
    endcase
  endfunction

  // Loads of these types sign-extend; the unsigned types zero-extend.
  function automatic logic dtype_signed(input logic [2:0] dt);
    dtype_signed = (dt == DT_BYTE) || (dt == DT_HALF) || (dt == DT_WORD);
  endfunction

endpackage

// File: rtl/lsu_bank_ram.sv
// Word-addressed RAM built from byte-wide lanes with per-lane write enables.
// Latency: read data appears one clock after the address is presented.
// Backpressure: none, accepts an access every cycle.
module lsu_bank_ram #(
  parameter int    NUM_LANES = 4,
  parameter int    DEPTH     = 1024,
  parameter string INIT_PATH = ""
) (
  input  logic                      clk,
  input  logic [$clog2(DEPTH)-1:0]  addr,
  input  logic [NUM_LANES-1:0]      we,
  input  logic [NUM_LANES*8-1:0]    wdata,
  output logic [NUM_LANES*8-1:0]    rdata
);

  // One byte per lane per word; lane l holds byte address word*NUM_LANES+l.
  logic [NUM_LANES-1:0][7:0] mem [DEPTH];

  // Byte-lane writes and a registered read of the addressed word.
  always_ff @(posedge clk) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (we[l]) mem[addr][l] <= wdata[8*l +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/lsu_pipe.sv
// Load/store unit: byte/half/word accesses to a banked RAM (misaligned ones split over two words) plus memory-mapped GPIO registers.
// Latency: response two cycles after accept, three when the access spans two RAM words.
// Backpressure: req_ready drops for the whole access; responses cannot be stalled.
module lsu_pipe
  import lsu_pipe_pkg::*;
#(
  parameter int    DATA_WIDTH    = 32,
  parameter int    ADDR_WIDTH    = 12,
  parameter int    NUM_GPIO      = 2,
  parameter int    GPIO_BASE     = 'hEF0,
  parameter string RAM_INIT_PATH = ""
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  input  logic                         req_we,
  input  logic [2:0]                   req_dtype,
  input  logic [DATA_WIDTH-1:0]        req_wdata,
  output logic                         rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_err,
  output logic [NUM_GPIO*DATA_WIDTH-1:0] gpio_out
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int OFF_W     = $clog2(NUM_LANES);
  localparam int IDX_W     = ADDR_WIDTH - OFF_W;
  localparam int DEPTH     = 2 ** IDX_W;
  localparam logic [31:0] GPIO_LO = 32'(GPIO_BASE);
  localparam logic [31:0] GPIO_HI = 32'(GPIO_BASE + NUM_LANES * NUM_GPIO);

  state_e                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [2:0]              dtype_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   lo_q;
  logic [DATA_WIDTH-1:0]   gpio_q [NUM_GPIO];

  logic [31:0]             a32;
  logic [OFF_W-1:0]        off;
  logic [IDX_W-1:0]        w0, w1;
  logic [3:0]              size;
  logic                    legal, in_gpio, gpio_ok, ram_acc, acc_err, split;
  logic [31:0]             gidx;
  logic [2*NUM_LANES-1:0]  mask2;
  logic [NUM_LANES-1:0]    lanes1, lanes2;

  logic [DATA_WIDTH-1:0]   data_lo, raw, wdata_rot, load_ext, gval, result;
  logic [2*DATA_WIDTH-1:0] gath;
  logic                    sign_bit, sgn;
  int                      nbits;

  logic [IDX_W-1:0]        ram_addr;
  logic [NUM_LANES-1:0]    ram_we;
  logic [DATA_WIDTH-1:0]   ram_rdata;

  // Decode the latched request: region, legality and which lanes of which word it touches.
  always_comb begin
    a32     = 32'(addr_q);
    off     = addr_q[OFF_W-1:0];
    w0      = addr_q[ADDR_WIDTH-1:OFF_W];
    w1      = w0 + IDX_W'(1);  // wraps from the last word to word 0
    size    = dtype_size(dtype_q);
    legal   = (size != 4'd0);
    in_gpio = (a32 >= GPIO_LO) && (a32 < GPIO_HI);
    gpio_ok = in_gpio && (dtype_q == DT_WORD) && (off == '0);
    ram_acc = legal && !in_gpio;
    acc_err = !legal || (in_gpio && !gpio_ok);
    gidx    = (a32 - GPIO_LO) >> OFF_W;
    mask2   = ram_acc ? ((2*NUM_LANES)'((32'd1 << size) - 32'd1) << off) : '0;
    lanes1  = mask2[NUM_LANES-1:0];
    lanes2  = mask2[2*NUM_LANES-1:NUM_LANES];
    split   = |lanes2;
  end

  // Byte steering: rotate store bytes onto lanes, gather load bytes, extend and pick the result.
  always_comb begin
    raw       = '0;
    wdata_rot = '0;
    load_ext  = '0;
    gval      = '0;
    result    = '0;
    // The first word was read at accept, so it is on the RAM output during ACC1 and held in lo_q after.
    data_lo   = (state == ACC1) ? ram_rdata : lo_q;
    gath      = {ram_rdata, data_lo};
    for (int j = 0; j < NUM_LANES; j++) begin
      raw[8*j +: 8]       = gath[8*(int'(off) + j) +: 8];
      wdata_rot[8*j +: 8] = wdata_q[8*((j + NUM_LANES - int'(off)) % NUM_LANES) +: 8];
    end
    case (size)
      4'd1:    sign_bit = raw[7];
      4'd2:    sign_bit = raw[15];
      default: sign_bit = raw[31];
    endcase
    sgn   = dtype_signed(dtype_q) & sign_bit;
    nbits = 8 * int'(size);
    for (int i = 0; i < DATA_WIDTH; i++) begin
      load_ext[i] = (i < nbits) ? raw[i] : sgn;
    end
    for (int g = 0; g < NUM_GPIO; g++) begin
      if (gidx == 32'(g)) gval = gpio_q[g];
    end
    if (acc_err || we_q)  result = '0;
    else if (in_gpio)     result = gval;
    else                  result = load_ext;
  end

  // RAM port: read the first word while accepting, then write first/second word or read the second.
  always_comb begin
    ram_addr = w0;
    ram_we   = '0;
    case (state)
      IDLE: ram_addr = req_addr[ADDR_WIDTH-1:OFF_W];
      ACC1: begin
        if (we_q) begin
          ram_addr = w0;
          ram_we   = lanes1;
        end else begin
          ram_addr = w1;
        end
      end
      ACC2: begin
        ram_addr = w1;
        if (we_q) ram_we = lanes2;
      end
      default: ram_addr = w0;
    endcase
  end

  lsu_bank_ram #(
    .NUM_LANES (NUM_LANES),
    .DEPTH     (DEPTH),
    .INIT_PATH (RAM_INIT_PATH)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (wdata_rot),
    .rdata (ram_rdata)
  );

  // Access sequencer with registered handshake, response and GPIO state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      dtype_q   <= '0;
      wdata_q   <= '0;
      lo_q      <= '0;
      for (int g = 0; g < NUM_GPIO; g++) gpio_q[g] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            we_q      <= req_we;
            dtype_q   <= req_dtype;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            state     <= ACC1;
          end
        end
        ACC1: begin
          lo_q <= ram_rdata;
          for (int g = 0; g < NUM_GPIO; g++) begin
            if (we_q && gpio_ok && (gidx == 32'(g))) gpio_q[g] <= wdata_q;
          end
          if (split) begin
            state <= ACC2;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= result;
            rsp_err   <= acc_err;
          end
        end
        ACC2: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= result;
          rsp_err   <= 1'b0;
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_GPIO; g++) begin : g_gpio
    assign gpio_out[g*DATA_WIDTH +: DATA_WIDTH] = gpio_q[g];
  end

endmodule

// File: tb/tb_lsu_pipe.sv
// Bench for lsu_pipe: directed vectors plus randomized traffic against a byte-array reference model.
// Latency: measured per request and compared with the model's 2/3-cycle expectation.
// Backpressure: waits on req_ready with a bounded budget.
module tb_lsu_pipe;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int NG = 2;
  localparam logic [11:0] PRE_A [7] = '{12'hEEC, 12'hEEF, 12'hEF8, 12'hEFC, 12'hF00, 12'hFF8, 12'hFFC};

  logic           clk = 1'b0;
  logic           reset;
  logic           req_valid;
  logic           req_ready;
  logic [AW-1:0]  req_addr;
  logic           req_we;
  logic [2:0]     req_dtype;
  logic [DW-1:0]  req_wdata;
  logic           rsp_valid;
  logic [DW-1:0]  rsp_rdata;
  logic           rsp_err;
  logic [NG*DW-1:0] gpio_out;

  always #5 clk = ~clk;

  lsu_pipe #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .NUM_GPIO      (NG),
    .GPIO_BASE     ('hEF0),
    .RAM_INIT_PATH ("")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_dtype (req_dtype),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .gpio_out  (gpio_out)
  );

  // Reference state: one entry per byte address, plus the GPIO registers.
  logic [7:0]  mem_m [4096];
  logic [31:0] gm [NG];
  int npass = 0;
  int nfail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert (obs === exp) begin
      npass++;
    end else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] gpio_exp();
    return {gm[1], gm[0]};
  endfunction

  // Behavioural reference: walk the accessed bytes one address at a time.
  task automatic model(input logic [11:0] a, input logic we, input logic [2:0] dt,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat);
    int size;
    bit sgn;
    logic [31:0] v;
    logic [63:0] m;
    rd = '0; er = 1'b0; lat = 2; v = '0; sgn = 1'b0;
    case (dt)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: begin size = 4; sgn = 1'b1; end
      3'd3: size = 1;
      3'd4: size = 2;
      default: size = 0;
    endcase
    if (size == 0) begin
      er = 1'b1;
    end else if (a >= 12'hEF0 && a < 12'hEF8) begin
      if (dt == 3'd2 && a[1:0] == 2'd0) begin
        if (we) gm[(a - 12'hEF0) / 4] = wd;
        else    rd = gm[(a - 12'hEF0) / 4];
      end else begin
        er = 1'b1;
      end
    end else begin
      if (int'(a % 4) + size > 4) lat = 3;
      for (int k = 0; k < size; k++) begin
        if (we) mem_m[(int'(a) + k) % 4096] = wd[8*k +: 8];
        else    v[8*k +: 8] = mem_m[(int'(a) + k) % 4096];
      end
      if (!we) begin
        m  = (64'd1 << (8*size)) - 64'd1;
        rd = (sgn && v[8*size-1]) ? (v | ~m[31:0]) : v;
      end
    end
  endtask

  // Drive one request and wait (bounded) for its response.
  task automatic xact(input logic [11:0] a, input logic we, input logic [2:0] dt,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_addr = a; req_we = we; req_dtype = dt; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic run(input string tag, input logic [11:0] a, input logic we,
                     input logic [2:0] dt, input logic [31:0] wd, output logic [31:0] rd);
    logic [31:0] erd;
    logic eer, er;
    int elat, lat;
    model(a, we, dt, wd, erd, eer, elat);
    xact(a, we, dt, wd, rd, er, lat);
    check({tag, "_rdata"}, 64'(rd), 64'(erd));
    check({tag, "_err"}, 64'(er), 64'(eer));
    check({tag, "_lat"}, 64'(lat), 64'(elat));
    check({tag, "_gpio"}, gpio_out, gpio_exp());
    @(negedge clk);
    check({tag, "_pulse"}, 64'(rsp_valid), 64'd0);
    check({tag, "_hold"}, 64'({rsp_err, rsp_rdata}), 64'({eer, erd}));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, observed no summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, pk0, pk1;
    logic [11:0] a;
    logic        we;
    logic [2:0]  dt;
    int          sel, hits;

    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
    req_dtype = '0; req_wdata = '0;
    for (int g = 0; g < NG; g++) gm[g] = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_err", 64'(rsp_err), 64'd0);
    check("rst_gpio", gpio_out, 64'd0);
    reset = 1'b0;

    // Give every byte the random traffic can reach a known value.
    for (int i = 0; i <= 64; i++) run("pre", 12'(i*4), 1'b1, 3'd2, $urandom, rd);
    for (int i = 0; i < 7; i++) run("pre", PRE_A[i], 1'b1, 3'd2, $urandom, rd);

    run("w_st", 12'h010, 1'b1, 3'd2, 32'hDEADBEEF, rd);
    run("w_ld", 12'h010, 1'b0, 3'd2, 32'h0, rd);
    check("w_ld_lit", 64'(rd), 64'hDEADBEEF);

    run("split_st", 12'h012, 1'b1, 3'd2, 32'h11223344, rd);
    run("bu_ld", 12'h015, 1'b0, 3'd3, 32'h0, rd);
    check("bu_ld_lit", 64'(rd), 64'h11);
    run("split_ld", 12'h012, 1'b0, 3'd2, 32'h0, rd);
    check("split_ld_lit", 64'(rd), 64'h11223344);

    run("b80_st", 12'h020, 1'b1, 3'd0, 32'h00000080, rd);
    run("bs_ld", 12'h020, 1'b0, 3'd0, 32'h0, rd);
    check("bs_ld_lit", 64'(rd), 64'hFFFFFF80);
    run("bu80_ld", 12'h020, 1'b0, 3'd3, 32'h0, rd);
    check("bu80_ld_lit", 64'(rd), 64'h80);

    pk0 = dut.u_ram.mem[10'h3BD];
    run("gpio_st", 12'hEF4, 1'b1, 3'd2, 32'hCAFEF00D, rd);
    check("gpio1_lit", 64'(gpio_out[63:32]), 64'hCAFEF00D);
    pk1 = dut.u_ram.mem[10'h3BD];
    check("gpio_ram_untouched", 64'(pk1), 64'(pk0));
    run("gpio_bad", 12'hEF0, 1'b1, 3'd0, 32'h000000AA, rd);
    run("gpio_ld", 12'hEF4, 1'b0, 3'd2, 32'h0, rd);

    run("ill_st", 12'h030, 1'b1, 3'd7, 32'h55555555, rd);
    check("ill_rdata_lit", 64'(rd), 64'd0);
    run("ill_chk", 12'h030, 1'b0, 3'd2, 32'h0, rd);
    run("wrap_st", 12'hFFF, 1'b1, 3'd1, 32'h0000BEEF, rd);
    run("wrap_lo", 12'hFFC, 1'b0, 3'd2, 32'h0, rd);
    run("wrap_hi", 12'h000, 1'b0, 3'd2, 32'h0, rd);
    run("wrap_ld", 12'hFFF, 1'b0, 3'd1, 32'h0, rd);
    check("wrap_ld_lit", 64'(rd), 64'hFFFFBEEF);

    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      we  = 1'($urandom_range(0, 1));
      dt  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      if (sel < 6)       a = 12'($urandom_range(0, 255));
      else if (sel == 6) begin
        a  = ($urandom_range(0, 1) == 1) ? 12'hEF0 : 12'hEF4;
        dt = 3'd2;
      end
      else if (sel < 8)  a = 12'($urandom_range(12'hEEC, 12'hEFF));
      else               a = 12'($urandom_range(12'hFF8, 12'hFFF));
      run("rand", a, we, dt, $urandom, rd);
    end

    // Abort a split store in its second access cycle.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 12'h016; req_we = 1'b1; req_dtype = 3'd2;
    req_wdata = 32'hA1B2C3D4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort_valid", 64'(rsp_valid), 64'd0);
    check("abort_ready", 64'(req_ready), 64'd1);
    check("abort_gpio", gpio_out, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    hits = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) hits++;
    end
    check("abort_noresp", 64'(hits), 64'd0);
    mem_m[12'h016] = 8'hD4;
    mem_m[12'h017] = 8'hC3;
    for (int g = 0; g < NG; g++) gm[g] = '0;
    run("abort_lo", 12'h014, 1'b0, 3'd2, 32'h0, rd);
    run("abort_hi", 12'h018, 1'b0, 3'd2, 32'h0, rd);

    $display("%0d/%0d checks passed", npass, npass + nfail);
    $finish;
  end

endmodule
